mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8: RAM word-address width.
REQ-002 Parameter DATA_W, default 32: RAM data width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on rising clk.
REQ-005 cpu_req  input  1  CPU access request, held until cpu_gnt.
REQ-006 cpu_we  input  1  CPU write (1) / read (0).
REQ-007 cpu_addr  input  ADDR_W  CPU word address.
REQ-008 cpu_wdata  input  DATA_W  CPU write data.
REQ-009 cpu_gnt  output  1  one-cycle pulse; CPU request accepted and driven to RAM.
REQ-010 cpu_rvalid  output  1  one-cycle pulse; cpu_rdata valid.
REQ-011 cpu_rdata  output  DATA_W  CPU read data.
REQ-012 dev_req, dev_we, dev_addr, dev_wdata, dev_gnt, dev_rvalid, dev_rdata: same directions, widths and meanings as the cpu_* ports, for the second requester (loader/display).
REQ-013 ram_addr  output  ADDR_W  RAM address.
REQ-014 ram_data  output  DATA_W  RAM write data.
REQ-015 ram_wren  output  1  RAM write enable.
REQ-016 ram_q  input  DATA_W  RAM read data; valid one clock after ram_addr is presented.

Function
REQ-017 The FSM SHALL have three states: IDLE, ACCESS, RESP.
REQ-018 IDLE: with no request, stay; with any request, register winner id, we, addr and wdata, then go to ACCESS.
REQ-019 ACCESS: drive ram_addr/ram_data from registers; ram_wren = registered we; pulse the winner's gnt; write goes to IDLE, read goes to RESP.
REQ-020 RESP: winner's rdata = ram_q, winner's rvalid pulses for exactly one cycle; go to IDLE.
REQ-021 Latency SHALL be: request sampled at edge n, gnt and ram_wren at cycle n+1, read rvalid at cycle n+2; writes occupy 2 cycles, reads 3.
REQ-022 ram_wren SHALL be high only in ACCESS for a write, for exactly one cycle per write.
REQ-023 With simultaneous requests, the winner SHALL be the CPU (fixed priority) unless the REQ-031 macro is defined.
REQ-024 A requester that keeps req high after its gnt SHALL be treated as issuing a new transaction.
REQ-025 The loser of arbitration SHALL keep its request pending without loss; it SHALL be granted in the next IDLE in which it wins.
REQ-026 rdata outputs SHALL hold their last value when rvalid is low; the non-winner's rvalid/gnt SHALL stay 0.
REQ-027 Requests arriving while in ACCESS or RESP SHALL be ignored until IDLE.

Reset
REQ-028 When reset is low at a rising edge, the FSM SHALL go to IDLE and the following SHALL be 0 from the next cycle: all gnt, rvalid, rdata outputs, ram_wren, ram_addr and ram_data.
REQ-029 Reset during ACCESS or RESP SHALL abort the transaction: no gnt, rvalid or ram_wren is issued after reset.
REQ-030 The last-served flag SHALL reset to DEV, so the CPU wins the first contention.

Configuration
REQ-031 With MEM_ARB_RR_EN defined, contention SHALL be round-robin: the winner is the requester not in the last-served flag, and the flag updates on every gnt. Without the macro, priority is fixed to the CPU and the flag is not implemented.

Structure
REQ-032 Package mem_arb_pkg SHALL hold the state enum (IDLE, ACCESS, RESP), the requester-id enum (CPU, DEV), and the ADDR_W/DATA_W defaults.
REQ-033 Winner selection SHALL be a sub-module arb_pick (combinational; inputs: two reqs and last-served flag; output: winner id).

Verification
REQ-034 CPU write addr 0x10, data 32'd7, dev idle -> cpu_gnt and ram_wren at cycle n+1 with ram_addr=0x10 and ram_data=7; a later CPU read of 0x10 -> cpu_rvalid at n+2 with cpu_rdata=7.
REQ-035 CPU and dev read simultaneously, macro off -> CPU granted first; dev granted 3 cycles later; both rvalids occur in order, one cycle each.
REQ-036 Same stimulus with MEM_ARB_RR_EN defined and held contention over 4 transactions -> grants alternate CPU, DEV, CPU, DEV.
REQ-037 Reset driven low during RESP of a dev read -> dev_rvalid never pulses; all outputs are 0 the next cycle; FSM is in IDLE.
REQ-038 Dev write to 0x3F with cpu_req raised in ACCESS -> CPU is granted in the cycle after the return to IDLE, and ram_wren is never high for two consecutive cycles.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-requester RAM arbiter.
// Optional round-robin contention: define MEM_ARB_RR_EN.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    typedef enum logic {
        CPU = 1'b0,
        DEV = 1'b1
    } rid_t;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection for two requesters.
// On contention the requester not served last wins.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic cpu_req,
    input  logic dev_req,
    input  rid_t last,
    output rid_t win
);

    // pick the winner among the active requests
    always_comb begin
        win = CPU;
        unique case (1'b1)
            (cpu_req & dev_req):
                win = (last == CPU) ? DEV : CPU;
            (cpu_req & ~dev_req):
                win = CPU;
            (~cpu_req & dev_req):
                win = DEV;
            default:
                win = CPU;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester single-port RAM arbiter (IDLE/ACCESS/RESP).
// Define MEM_ARB_RR_EN for round-robin; default is CPU priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dev_req,
    input  logic              dev_we,
    input  logic [ADDR_W-1:0] dev_addr,
    input  logic [DATA_W-1:0] dev_wdata,
    output logic              dev_gnt,
    output logic              dev_rvalid,
    output logic [DATA_W-1:0] dev_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q
);

    state_t            state;
    state_t            nxt;
    rid_t              win_q;
    rid_t              pick;
    rid_t              last;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] cpu_rd_q;
    logic [DATA_W-1:0] dev_rd_q;
    logic              load;
    logic              acc;
    logic              rsp;

    arb_pick u_pick (
        .cpu_req (cpu_req),
        .dev_req (dev_req),
        .last    (last),
        .win     (pick)
    );

`ifdef MEM_ARB_RR_EN
    // last-served flag, refreshed on every grant
    always_ff @(posedge clk) begin
        if (!reset) begin
            last <= DEV;
        end else if (acc) begin
            last <= win_q;
        end
    end
`else
    // flag pinned to DEV makes the CPU win every contention
    assign last = DEV;
`endif

    // state register and captured transaction
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            win_q   <= CPU;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state <= nxt;
            if (load) begin
                win_q <= pick;
                if (pick == CPU) begin
                    we_q    <= cpu_we;
                    addr_q  <= cpu_addr;
                    wdata_q <= cpu_wdata;
                end else begin
                    we_q    <= dev_we;
                    addr_q  <= dev_addr;
                    wdata_q <= dev_wdata;
                end
            end
        end
    end

    // next-state decode; requests only sampled in IDLE
    always_comb begin
        nxt  = state;
        load = 1'b0;
        unique case (state)
            IDLE: begin
                if (cpu_req | dev_req) begin
                    nxt  = ACCESS;
                    load = 1'b1;
                end
            end
            ACCESS:  nxt = we_q ? IDLE : RESP;
            RESP:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // pulses are suppressed while reset is low so an
    // interrupted transaction never completes
    assign acc = (state == ACCESS) & reset;
    assign rsp = (state == RESP) & reset;

    assign cpu_gnt    = acc & (win_q == CPU);
    assign dev_gnt    = acc & (win_q == DEV);
    assign cpu_rvalid = rsp & (win_q == CPU);
    assign dev_rvalid = rsp & (win_q == DEV);

    assign ram_wren = acc & we_q;
    assign ram_addr = addr_q;
    assign ram_data = wdata_q;

    assign cpu_rdata = cpu_rvalid ? ram_q : cpu_rd_q;
    assign dev_rdata = dev_rvalid ? ram_q : dev_rd_q;

    // remember last delivered read data per requester
    always_ff @(posedge clk) begin
        if (!reset) begin
            cpu_rd_q <= '0;
            dev_rd_q <= '0;
        end else begin
            if (cpu_rvalid) cpu_rd_q <= ram_q;
            if (dev_rvalid) dev_rd_q <= ram_q;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a transaction-level model.
// Build with MEM_ARB_RR_EN to check round-robin contention.
module tb_mem_arbiter;

    localparam int AW = 8;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_gnt;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          dev_req = 1'b0;
    logic          dev_we = 1'b0;
    logic [AW-1:0] dev_addr = '0;
    logic [DW-1:0] dev_wdata = '0;
    logic          dev_gnt;
    logic          dev_rvalid;
    logic [DW-1:0] dev_rdata;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data;
    logic          ram_wren;
    logic [DW-1:0] ram_q = '0;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .dev_req    (dev_req),
        .dev_we     (dev_we),
        .dev_addr   (dev_addr),
        .dev_wdata  (dev_wdata),
        .dev_gnt    (dev_gnt),
        .dev_rvalid (dev_rvalid),
        .dev_rdata  (dev_rdata),
        .ram_addr   (ram_addr),
        .ram_data   (ram_data),
        .ram_wren   (ram_wren),
        .ram_q      (ram_q)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]    side;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t          gq[$];
    exp_t          rq[$];
    logic [DW-1:0] mem[256];
    logic [DW-1:0] mm[256];
    int            nvec = 0;
    int            nerr = 0;
    int            cyc = 0;
    int            nxt_smp = 0;
    int            last = 1;
    bit            rst_seen = 1'b0;
    bit            prev_wren = 1'b0;
    logic [DW-1:0] ecr = '0;
    logic [DW-1:0] edr = '0;

    task automatic chk(input string nm,
                       input logic [127:0] got,
                       input logic [127:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", nm, got, exp);
        end
    endtask

    // behavioural RAM: one-cycle read latency
    always @(posedge clk) begin
        if (ram_wren) mem[ram_addr] <= ram_data;
        ram_q <= mem[ram_addr];
    end

    // reference model: one decision per free IDLE edge
    always @(posedge clk) begin
        exp_t e;
        int   w;
        cyc = cyc + 1;
        if (!reset) begin
            gq.delete();
            rq.delete();
            nxt_smp  = cyc + 1;
            last     = 1;
            rst_seen = 1'b1;
        end else begin
            rst_seen = 1'b0;
            if (cyc >= nxt_smp && (cpu_req || dev_req)) begin
`ifdef MEM_ARB_RR_EN
                if (cpu_req && dev_req) w = (last == 0) ? 1 : 0;
                else w = cpu_req ? 0 : 1;
`else
                w = cpu_req ? 0 : 1;
`endif
                e.side = (w == 0) ? 2'b10 : 2'b01;
                e.we   = (w == 0) ? cpu_we : dev_we;
                e.addr = (w == 0) ? cpu_addr : dev_addr;
                e.data = (w == 0) ? cpu_wdata : dev_wdata;
                e.cyc  = cyc;
                gq.push_back(e);
                if (e.we) begin
                    mm[e.addr] = e.data;
                    nxt_smp = cyc + 2;
                end else begin
                    e.data = mm[e.addr];
                    e.cyc  = cyc + 1;
                    rq.push_back(e);
                    nxt_smp = cyc + 3;
                end
                last = w;
            end
        end
    end

    // monitor: pops expectations when the DUT pulses
    always @(negedge clk) begin
        exp_t          g;
        logic [DW-1:0] rd;
        if (rst_seen) begin
            chk("reset_zero",
                128'({cpu_gnt, dev_gnt, cpu_rvalid, dev_rvalid,
                      ram_wren, ram_addr, ram_data,
                      cpu_rdata, dev_rdata}), 128'(0));
            ecr = '0;
            edr = '0;
        end
        if (!reset) begin
            chk("abort_quiet",
                128'({cpu_gnt, dev_gnt, cpu_rvalid,
                      dev_rvalid, ram_wren}), 128'(0));
            gq.delete();
            rq.delete();
        end else begin
            if (cpu_gnt || dev_gnt) begin
                if (gq.size() == 0) begin
                    chk("gnt_unexp", 128'({cpu_gnt, dev_gnt}),
                        128'(0));
                end else begin
                    g = gq.pop_front();
                    chk("gnt",
                        128'({cpu_gnt, dev_gnt, ram_wren, ram_addr,
                              g.we ? ram_data : g.data, cyc}),
                        128'({g.side, g.we, g.addr, g.data, g.cyc}));
                end
            end else if (ram_wren) begin
                chk("wren_no_gnt", 128'(ram_wren), 128'(0));
            end
            if (cpu_rvalid || dev_rvalid) begin
                rd = cpu_rvalid ? cpu_rdata : dev_rdata;
                if (rq.size() == 0) begin
                    chk("rvalid_unexp",
                        128'({cpu_rvalid, dev_rvalid}), 128'(0));
                end else begin
                    g = rq.pop_front();
                    chk("rvalid",
                        128'({cpu_rvalid, dev_rvalid, rd, cyc}),
                        128'({g.side, g.data, g.cyc}));
                    if (g.side == 2'b10) ecr = g.data;
                    else edr = g.data;
                end
            end
            chk("rdata_hold", 128'({cpu_rdata, dev_rdata}),
                128'({ecr, edr}));
            while (gq.size() != 0 && gq[0].cyc < cyc) begin
                g = gq.pop_front();
                chk("gnt_missing", 128'(0), 128'(g.cyc));
            end
            while (rq.size() != 0 && rq[0].cyc < cyc) begin
                g = rq.pop_front();
                chk("rvalid_missing", 128'(0), 128'(g.cyc));
            end
        end
        if (prev_wren && ram_wren) begin
            chk("wren_2cyc", 128'(ram_wren), 128'(0));
        end
        prev_wren = ram_wren;
    end

    // one cycle step; a grant retires the pending request
    task automatic tick();
        @(posedge clk);
        #1;
        if (cpu_gnt) cpu_req = 1'b0;
        if (dev_gnt) dev_req = 1'b0;
    endtask

    task automatic wait_idle(input int lim);
        for (int i = 0; i < lim; i++) begin
            if (!cpu_req && !dev_req) break;
            tick();
        end
        chk("wait_timeout", 128'({cpu_req, dev_req}), 128'(0));
    endtask

    task automatic set_cpu(input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = d;
    endtask

    task automatic set_dev(input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        dev_req   = 1'b1;
        dev_we    = we;
        dev_addr  = a;
        dev_wdata = d;
    endtask

    initial begin
        int ng;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 32'hA500_0000 + DW'(i * 3);
            mm[i]  = 32'hA500_0000 + DW'(i * 3);
        end
        repeat (3) tick();
        reset = 1'b1;
        tick();

        // CPU write then read back
        set_cpu(1'b1, 8'h10, 32'd7);
        wait_idle(10);
        tick();
        set_cpu(1'b0, 8'h10, 32'd0);
        wait_idle(10);
        repeat (2) tick();

        // simultaneous reads
        set_cpu(1'b0, 8'h10, 32'd0);
        set_dev(1'b0, 8'h11, 32'd0);
        wait_idle(20);
        repeat (2) tick();

        // held contention over four grants
        set_cpu(1'b0, 8'h20, 32'd0);
        set_dev(1'b0, 8'h21, 32'd0);
        ng = 0;
        for (int i = 0; i < 40 && ng < 4; i++) begin
            tick();
            if (!cpu_req) begin
                ng++;
                if (ng < 4) set_cpu(1'b0, AW'(8'h20 + ng), 32'd0);
            end
            if (!dev_req && ng < 4) begin
                ng++;
                if (ng < 4) set_dev(1'b0, AW'(8'h30 + ng), 32'd0);
            end
        end
        wait_idle(20);
        repeat (2) tick();

        // dev write, CPU raises its request during ACCESS
        set_dev(1'b1, 8'h3F, 32'hCAFE_0001);
        for (int i = 0; i < 10 && dev_req; i++) tick();
        set_cpu(1'b0, 8'h3F, 32'd0);
        wait_idle(10);
        repeat (2) tick();

        // reset during RESP of a dev read
        set_dev(1'b0, 8'h3F, 32'd0);
        for (int i = 0; i < 10 && dev_req; i++) tick();
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        // random traffic
        repeat (600) begin
            tick();
            if (!cpu_req && $urandom_range(0, 2) != 0)
                set_cpu(1'($urandom_range(0, 1)),
                        AW'($urandom_range(0, 15)), $urandom);
            if (!dev_req && $urandom_range(0, 2) != 0)
                set_dev(1'($urandom_range(0, 1)),
                        AW'($urandom_range(0, 15)), $urandom);
        end
        wait_idle(30);
        repeat (5) tick();
        chk("drain", 128'(gq.size() + rq.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nerr);
        $finish;
    end

endmodule
